// File: rtl/femto_ifq_pkg.sv
// femto_ifq_pkg: shared types and helpers for the femto instruction fetch queue
package femto_ifq_pkg;
    typedef logic [15:0] hword_t;
    localparam int ILEN_HW_MAX = 2;
    function automatic logic is_rvc(hword_t h);
        return h[1:0] != 2'b11;
    endfunction
endpackage

// File: rtl/instr_halfword_queue_if.sv
// instr_halfword_queue_if: fetch-side and decode-side handshake of the halfword queue
interface instr_halfword_queue_if #(
    parameter int IN_HW    = 2,
    parameter int DEPTH_HW = 8
);
    localparam int CNT_W = $clog2(DEPTH_HW + 1);
    localparam int FW    = (IN_HW > 1) ? $clog2(IN_HW) : 1;
    logic                  in_valid;
    logic                  in_ready;
    logic [16*IN_HW-1:0]   in_data;
    logic [FW-1:0]         in_first;
    logic                  out_valid;
    logic                  out_is16;
    logic [31:0]           out_data;
    logic                  out_pop;
    logic [CNT_W-1:0]      filled_hw;
    logic [CNT_W-1:0]      vacant_hw;
    modport master (
        output in_valid, in_data, in_first, out_pop,
        input  in_ready, out_valid, out_is16, out_data, filled_hw, vacant_hw
    );
    modport slave (
        input  in_valid, in_data, in_first, out_pop,
        output in_ready, out_valid, out_is16, out_data, filled_hw, vacant_hw
    );
endinterface

// File: rtl/instr_halfword_queue.sv
// instr_halfword_queue: halfword-granular instruction prefetch queue feeding the decoder
module instr_halfword_queue
    import femto_ifq_pkg::*;
#(
    parameter int IN_HW    = 2,
    parameter int DEPTH_HW = 8
) (
    input logic                   clk,
    input logic                   rstn,
    input logic                   clr,
    instr_halfword_queue_if.slave q
);
    localparam int CNT_W = $clog2(DEPTH_HW + 1);
    localparam int PW    = $clog2(DEPTH_HW);
    hword_t           mem [DEPTH_HW];
    logic [PW-1:0]    rd_ptr, wr_ptr;
    logic [CNT_W-1:0] count, n_push, n_pop;
    hword_t           h0, h1;
    logic             push, pop;
    always_comb begin
        h0 = mem[rd_ptr];
        h1 = mem[rd_ptr + PW'(1)];
        q.filled_hw = count;
        q.vacant_hw = CNT_W'(DEPTH_HW) - count;
        q.in_ready = q.vacant_hw >= CNT_W'(IN_HW);
        q.out_is16 = (count != '0) && is_rvc(h0);
        q.out_valid = q.out_is16 || (count >= CNT_W'(2));
        q.out_data = {count >= CNT_W'(2) ? h1 : 16'h0, count != '0 ? h0 : 16'h0};
        push = q.in_valid && q.in_ready && !clr;
        pop = q.out_pop && q.out_valid && !clr;
        n_push = push ? CNT_W'(IN_HW) - CNT_W'(q.in_first) : '0;
        n_pop = !pop ? '0 : q.out_is16 ? CNT_W'(1) : CNT_W'(ILEN_HW_MAX);
    end
    always_ff @(posedge clk) begin
        if (!rstn || clr) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr + PW'(n_pop);
            wr_ptr <= wr_ptr + PW'(n_push);
            count  <= count + n_push - n_pop;
        end
    end
    // halfwords below in_first are skipped; the rest pack contiguously from wr_ptr
    always_ff @(posedge clk) begin
        if (rstn && push)
            for (int i = 0; i < IN_HW; i++)
                if (i >= int'(q.in_first))
                    mem[wr_ptr + PW'(i - int'(q.in_first))] <= q.in_data[16*i +: 16];
    end
endmodule

// File: tb/tb_instr_halfword_queue.sv
// tb_instr_halfword_queue: random and directed checks against a halfword-queue model
module tb_instr_halfword_queue;
    localparam int IN_HW = 2, DEPTH_HW = 8;
    logic clk = 0, rstn = 0, clr = 0;
    int checks = 0, errors = 0;
    logic [15:0] mq[$];
    instr_halfword_queue_if #(.IN_HW(IN_HW), .DEPTH_HW(DEPTH_HW)) q();
    instr_halfword_queue #(.IN_HW(IN_HW), .DEPTH_HW(DEPTH_HW)) dut (
        .clk(clk), .rstn(rstn), .clr(clr), .q(q)
    );
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic m_is16();
        return mq.size() >= 1 && mq[0][1:0] != 2'b11;
    endfunction

    function automatic logic m_valid();
        return m_is16() || mq.size() >= 2;
    endfunction

    task automatic check_model();
        logic [31:0] ed;
        int n;
        n = mq.size();
        ed = '0;
        if (n >= 1) ed[15:0] = mq[0];
        if (n >= 2) ed[31:16] = mq[1];
        check("filled_hw", 32'(q.filled_hw), 32'(n));
        check("vacant_hw", 32'(q.vacant_hw), 32'(DEPTH_HW - n));
        check("in_ready", 32'(q.in_ready), 32'(DEPTH_HW - n >= IN_HW));
        check("out_is16", 32'(q.out_is16), 32'(m_is16()));
        check("out_valid", 32'(q.out_valid), 32'(m_valid()));
        check("out_data", q.out_data, ed);
    endtask

    // drive one cycle at negedge, advance the model, compare after the next edge
    task automatic cyc(input logic v, input logic [31:0] d, input logic f,
                       input logic p, input logic c, input logic r = 1'b1);
        int n;
        logic e16, ev;
        n = mq.size();
        e16 = m_is16();
        ev = m_valid();
        q.in_valid = v;
        q.in_data = d;
        q.in_first = f;
        q.out_pop = p;
        clr = c;
        rstn = r;
        if (!r || c) mq.delete();
        else begin
            if (p && ev) repeat (e16 ? 1 : 2) void'(mq.pop_front());
            if (v && DEPTH_HW - n >= IN_HW)
                for (int i = int'(f); i < IN_HW; i++) mq.push_back(d[16*i +: 16]);
        end
        @(posedge clk);
        @(negedge clk);
        check_model();
    endtask

    function automatic logic [15:0] rand_hw();
        logic [15:0] h;
        h = 16'($urandom);
        if ($urandom_range(0, 1) == 0) h[1:0] = 2'b11;
        return h;
    endfunction

    initial begin
        q.in_valid = 0;
        q.in_data = '0;
        q.in_first = '0;
        q.out_pop = 0;
        @(negedge clk);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        check("rst_filled", 32'(q.filled_hw), 0);
        check("rst_vacant", 32'(q.vacant_hw), 8);
        check("rst_in_ready", 32'(q.in_ready), 1);
        check("rst_out_valid", 32'(q.out_valid), 0);
        check("rst_out_data", q.out_data, 0);
        cyc(1, 32'h00B3_4501, 0, 0, 0);
        check("tp_push_filled", 32'(q.filled_hw), 2);
        check("tp_push_is16", 32'(q.out_is16), 1);
        check("tp_push_data", q.out_data, 32'h00B3_4501);
        cyc(0, 0, 0, 1, 0);
        check("tp_lone_filled", 32'(q.filled_hw), 1);
        check("tp_lone_is16", 32'(q.out_is16), 0);
        check("tp_lone_valid", 32'(q.out_valid), 0);
        cyc(0, 0, 0, 1, 0);
        check("tp_lone_pop_ignored", 32'(q.filled_hw), 1);
        cyc(1, 32'h0001_0513, 0, 0, 0);
        check("tp_join_filled", 32'(q.filled_hw), 3);
        check("tp_join_data", q.out_data, 32'h0513_00B3);
        check("tp_join_valid", 32'(q.out_valid), 1);
        cyc(0, 0, 0, 0, 1);
        cyc(1, 32'h4505_1111, 1, 0, 0);
        check("tp_branch_filled", 32'(q.filled_hw), 1);
        check("tp_branch_data", q.out_data, 32'h0000_4505);
        check("tp_branch_is16", 32'(q.out_is16), 1);
        repeat (3) cyc(1, 32'h0001_0001, 0, 0, 0);
        check("tp_full7_filled", 32'(q.filled_hw), 7);
        check("tp_full7_ready", 32'(q.in_ready), 0);
        cyc(1, 32'h0001_0001, 0, 0, 0);
        check("tp_blocked_filled", 32'(q.filled_hw), 7);
        cyc(0, 0, 0, 1, 0);
        check("tp_pop6_filled", 32'(q.filled_hw), 6);
        check("tp_pop6_ready", 32'(q.in_ready), 1);
        cyc(0, 0, 0, 0, 1);
        repeat (3) cyc(1, 32'h0001_0001, 0, 0, 0);
        cyc(1, 32'h0001_0001, 1, 0, 0);
        repeat (7) cyc(0, 0, 0, 1, 0);
        cyc(1, 32'h0010_0093, 0, 0, 0);
        check("tp_wrap_data", q.out_data, 32'h0010_0093);
        check("tp_wrap_is16", 32'(q.out_is16), 0);
        check("tp_wrap_valid", 32'(q.out_valid), 1);
        cyc(0, 0, 0, 1, 0);
        check("tp_wrap_pop", 32'(q.filled_hw), 0);
        repeat (2) cyc(1, 32'h0010_0093, 0, 0, 0);
        cyc(1, 32'h0010_0093, 0, 1, 0);
        check("tp_pushpop_filled", 32'(q.filled_hw), 4);
        cyc(1, 32'h0010_0093, 0, 1, 1);
        check("tp_clr_all_filled", 32'(q.filled_hw), 0);
        for (int k = 0; k < 4000; k++)
            cyc($urandom_range(0, 3) != 0, {rand_hw(), rand_hw()}, 1'($urandom_range(0, 1)),
                $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0, $urandom_range(0, 250) != 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
